// File: rtl/popcount_seq.sv
// Multi-cycle population counter: counts ones (or zeros) CHUNK bits per clock, keeps a saturating total.
// Optional macro POPCOUNT_PARITY_EN adds parity_out (LSB of the final count).
module popcount_seq #(
  parameter  int WIDTH = 32,
  parameter  int CHUNK = 4,
  parameter  int ACC_W = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             mode_zeros,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count_out,
  output logic [ACC_W-1:0] total_out,
  output logic             total_sat,
  input  logic             acc_clr
`ifdef POPCOUNT_PARITY_EN
  ,
  output logic             parity_out
`endif
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int PS_W  = $clog2(CHUNK + 1);
  localparam int SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_shift;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_count;
  logic [ACC_W-1:0]   r_total;
  logic               r_sat;
  logic               w_accept, w_last;
  logic [PS_W-1:0]    w_part;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [ACC_W-1:0]   w_base;
  logic [SUM_W-1:0]   w_sum;

  function automatic logic [PS_W-1:0] f_pop(input logic [CHUNK-1:0] v);
    logic [PS_W-1:0] s;
    s = '0;
    for (int i = 0; i < CHUNK; i++) s = s + PS_W'(v[i]);
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_COUNT;
        end
      end
      S_COUNT: begin
        if (r_idx == IDX_W'(N - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_part    = f_pop(r_shift[CHUNK-1:0]);
  assign w_cnt_nxt = r_cnt + CNT_W'(w_part);

  // A coincident clear drops the old total before this word's count is added.
  assign w_base = acc_clr ? '0 : r_total;
  assign w_sum  = {1'b0, w_base} + SUM_W'(w_cnt_nxt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_count <= '0;
      r_total <= '0;
      r_sat   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shift <= mode_zeros ? ~data_in : data_in;
        r_idx   <= '0;
        r_cnt   <= '0;
      end else if (r_state == S_COUNT) begin
        r_shift <= r_shift >> CHUNK;
        r_idx   <= r_idx + 1'b1;
        r_cnt   <= w_cnt_nxt;
      end

      if (w_last) begin
        r_count <= w_cnt_nxt;
        if (w_sum[ACC_W]) begin
          r_total <= '1;
          r_sat   <= 1'b1;
        end else begin
          r_total <= w_sum[ACC_W-1:0];
          r_sat   <= acc_clr ? 1'b0 : r_sat;
        end
      end else if (acc_clr) begin
        r_total <= '0;
        r_sat   <= 1'b0;
      end
    end
  end

  assign count_out = r_count;
  assign total_out = r_total;
  assign total_sat = r_sat;

`ifdef POPCOUNT_PARITY_EN
  logic r_parity;
  always_ff @(posedge clk) begin
    if (!rst_n)      r_parity <= 1'b0;
    else if (w_last) r_parity <= w_cnt_nxt[0];
  end
  assign parity_out = r_parity;
`endif

endmodule
